// File: rtl/regfile_mp_bypass.sv
// regfile_mp_bypass: multi-port register file with same-edge write bypass and pending scoreboard
module regfile_mp_bypass #(
   parameter int XLEN = 32,
   parameter int NREGS = 32,
   parameter int NREAD = 2,
   localparam int AW = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we0,
   input  logic [AW-1:0]         waddr0,
   input  logic [XLEN-1:0]       wdata0,
   input  logic                  we1,
   input  logic [AW-1:0]         waddr1,
   input  logic [XLEN-1:0]       wdata1,
   input  logic [NREAD*AW-1:0]   raddr,
   output logic [NREAD*XLEN-1:0] rdata,
   output logic [NREAD-1:0]      rpend,
   input  logic                  issue_en,
   input  logic [AW-1:0]         issue_rd,
   output logic [NREGS-1:0]      pend_vec
);
   logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
   logic [NREGS-1:0]           pend_q, pend_d;
   logic [NREAD*XLEN-1:0]      rdata_q, rdata_d;
   logic [NREAD-1:0]           rpend_q, rpend_d;
   logic                       wr0, wr1, iss;
   assign wr0 = we0 && waddr0 != '0;
   assign wr1 = we1 && waddr1 != '0;
   assign iss = issue_en && issue_rd != '0;
   always_comb begin
      regs_d = regs_q;
      pend_d = pend_q;
      rdata_d = '0;
      rpend_d = '0;
      if (wr0) begin
         regs_d[waddr0] = wdata0;
         pend_d[waddr0] = 1'b0;
      end
      if (wr1) begin
         regs_d[waddr1] = wdata1;
         pend_d[waddr1] = 1'b0;
      end
      if (iss) pend_d[issue_rd] = 1'b1;
      for (int k = 0; k < NREAD; k++) begin
         rdata_d[k*XLEN +: XLEN] = regs_d[raddr[k*AW +: AW]];
         rpend_d[k] = pend_d[raddr[k*AW +: AW]];
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q <= '0;
         pend_q <= '0;
         rdata_q <= '0;
         rpend_q <= '0;
      end else begin
         regs_q <= regs_d;
         pend_q <= pend_d;
         rdata_q <= rdata_d;
         rpend_q <= rpend_d;
      end
   end
   assign rdata = rdata_q;
   assign rpend = rpend_q;
   assign pend_vec = pend_q;
endmodule
